nn_host_sequencer: RTL

//  Host-side initiator for the NeuralNetwork memory-mapped port: the master end of the

---
 rtl/nn_host_sequencer_if.sv | 39 +++
 rtl/nn_host_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/nn_host_sequencer_if.sv
// Host command/response stream plus the NN memory-mapped port.
// master: the sequencer; slave: host and NN side.
interface nn_host_sequencer_if #(
  parameter int MM_DEPTH = 16,
  parameter int MM_SIZE  = 16,
  parameter int Q_SIZE   = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [MM_DEPTH-1:0] cmd_addr;
  logic [MM_SIZE-1:0]  cmd_data;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [Q_SIZE-1:0]   rsp_data;
  logic                rsp_error;
  logic                nn_write_enable;
  logic [MM_DEPTH-1:0] nn_write_addr;
  logic [MM_SIZE-1:0]  nn_write_data;
  logic [MM_DEPTH-1:0] nn_read_addr;
  logic [Q_SIZE-1:0]   nn_read_data;
  logic                nn_busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  rsp_ready, nn_read_data, nn_busy,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output nn_write_enable, nn_write_addr,
    output nn_write_data, nn_read_addr
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    output rsp_ready, nn_read_data, nn_busy,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  nn_write_enable, nn_write_addr,
    input  nn_write_data, nn_read_addr
  );
endinterface

// File: rtl/nn_host_sequencer.sv
// Host-side initiator for the NN memory-mapped port.
// Turns WRITE/READ/WAIT commands into strobes, timed reads, busy polls.
module nn_host_sequencer #(
  parameter int MM_DEPTH     = 16,
  parameter int MM_SIZE      = 16,
  parameter int Q_SIZE       = 16,
  parameter int READ_LATENCY = 2,
  parameter int BUSY_GUARD   = 2,
  parameter int TIMEOUT      = 1024
) (
  input logic               clk,
  input logic               reset,
  nn_host_sequencer_if.master bus
);
  localparam int MAX_A =
    (READ_LATENCY > BUSY_GUARD) ? READ_LATENCY : BUSY_GUARD;
  localparam int MAX_V = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
  localparam int CW = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] RD_LAST = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] GD_LAST = CW'(BUSY_GUARD - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT_GUARD,
    S_WAIT_BUSY,
    S_RESP
  } state_t;

  state_t              r_state, w_state;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic                r_cmd_ready, w_cmd_ready;
  logic                r_rsp_valid, w_rsp_valid;
  logic [Q_SIZE-1:0]   r_rsp_data, w_rsp_data;
  logic                r_rsp_error, w_rsp_error;
  logic                r_we, w_we;
  logic [MM_DEPTH-1:0] r_waddr, w_waddr;
  logic [MM_SIZE-1:0]  r_wdata, w_wdata;
  logic [MM_DEPTH-1:0] r_raddr, w_raddr;

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.rsp_valid       = r_rsp_valid;
  assign bus.rsp_data        = r_rsp_data;
  assign bus.rsp_error       = r_rsp_error;
  assign bus.nn_write_enable = r_we;
  assign bus.nn_write_addr   = r_waddr;
  assign bus.nn_write_data   = r_wdata;
  assign bus.nn_read_addr    = r_raddr;

  // Next state, counter and response payload.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_rsp_data  = r_rsp_data;
    w_rsp_error = r_rsp_error;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_cnt = '0;
          case (bus.cmd_op)
            2'b00: w_state = S_WRITE;
            2'b01: w_state = S_READ;
            2'b10: w_state = (BUSY_GUARD == 0) ?
                             S_WAIT_BUSY : S_WAIT_GUARD;
            default: begin
              w_state     = S_RESP;
              w_rsp_data  = '0;
              w_rsp_error = 1'b1;
            end
          endcase
        end
      end
      S_WRITE: w_state = S_IDLE;
      S_READ: begin
        if (r_cnt == RD_LAST) begin
          w_state     = S_RESP;
          w_rsp_data  = bus.nn_read_data;
          w_rsp_error = 1'b0;
        end else begin
          w_cnt = r_cnt + ONE;
        end
      end
      S_WAIT_GUARD: begin
        if (r_cnt == GD_LAST) begin
          w_state = S_WAIT_BUSY;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + ONE;
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.nn_busy) begin
          w_state     = S_RESP;
          w_rsp_data  = '0;
          w_rsp_error = 1'b0;
        end else if (r_cnt == TO_LAST) begin
          w_state     = S_RESP;
          w_rsp_data  = '0;
          w_rsp_error = 1'b1;
        end else begin
          w_cnt = r_cnt + ONE;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state     = S_IDLE;
          w_rsp_data  = '0;
          w_rsp_error = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state.
  // WRITE is only entered from IDLE, so the bus still holds the command.
  always_comb begin
    w_cmd_ready = (w_state == S_IDLE);
    w_rsp_valid = (w_state == S_RESP);
    w_we        = (w_state == S_WRITE);
    w_waddr     = w_we ? bus.cmd_addr : '0;
    w_wdata     = w_we ? bus.cmd_data : '0;
    w_raddr     = '0;
    if (w_state == S_READ) begin
      w_raddr = (r_state == S_READ) ? r_raddr : bus.cmd_addr;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_raddr     <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_data  <= w_rsp_data;
      r_rsp_error <= w_rsp_error;
      r_we        <= w_we;
      r_waddr     <= w_waddr;
      r_wdata     <= w_wdata;
      r_raddr     <= w_raddr;
    end
  end
endmodule
